// File: rtl/vedic_div_16by8.sv
// rtl/vedic_div_16by8.sv - sequential restoring divider, 2W/W bits, one quotient bit per clock
// Optional overflow/divide-by-zero early exit: define DIV_OVF_CHECK_EN.
module vedic_div_16by8 #(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2*W-1:0] dividend,
    input  logic [W-1:0]   divisor,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   quotient,
    output logic [W-1:0]   remainder,
    output logic           err
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic          accept;
    logic          last;
    logic          ovf;

    logic [W-1:0]  r_q;
    logic [W-1:0]  q_q;
    logic [W-1:0]  d_q;
    logic [CW-1:0] cnt;

    logic [W:0]    t;
    logic [W:0]    diff;
    logic          ge;
    logic [W-1:0]  r_nxt;
    logic [W-1:0]  q_nxt;

`ifdef DIV_OVF_CHECK_EN
    // A high half at or above the divisor cannot yield a W-bit quotient; divisor=0 lands here too.
    assign ovf = (dividend[2*W-1:W] >= divisor);
`else
    assign ovf = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; handshake outputs depend on the state register only.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        accept    = 1'b0;
        last      = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept    = 1'b1;
                    state_nxt = ovf ? DONE : RUN;
                end
            end
            RUN: begin
                if (cnt == CNT_LAST) begin
                    last      = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // One restoring step: shift the next dividend bit into the partial remainder and try a subtract.
    always_comb begin
        t     = {r_q, q_q[W-1]};
        diff  = t - {1'b0, d_q};
        ge    = (t >= {1'b0, d_q});
        r_nxt = ge ? diff[W-1:0] : t[W-1:0];
        q_nxt = {q_q[W-2:0], ge};
    end

    // Working registers: load on accept, iterate while running.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= '0;
            q_q <= '0;
            d_q <= '0;
            cnt <= '0;
        end else if (accept) begin
            r_q <= dividend[2*W-1:W];
            q_q <= dividend[W-1:0];
            d_q <= divisor;
            cnt <= '0;
        end else if (state == RUN) begin
            r_q <= r_nxt;
            q_q <= q_nxt;
            cnt <= cnt + 1'b1;
        end
    end

    // Result registers change only when entering DONE, so they hold through IDLE and RUN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            quotient  <= '0;
            remainder <= '0;
        end else if (last) begin
            quotient  <= q_nxt;
            remainder <= r_nxt;
        end else if (accept && ovf) begin
            quotient  <= '1;
            remainder <= '0;
        end
    end

`ifdef DIV_OVF_CHECK_EN
    logic err_q;

    // Error flag is set only by the early-exit path and cleared by any completed iteration run.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (last) begin
            err_q <= 1'b0;
        end else if (accept && ovf) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_vedic_div_16by8.sv
// tb/tb_vedic_div_16by8.sv - scoreboard bench for vedic_div_16by8
module tb_vedic_div_16by8;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  quotient;
    logic [7:0]  remainder;
    logic        err;

    vedic_div_16by8 #(.W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .remainder (remainder),
        .err       (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] q;
        logic [7:0] r;
        logic       e;
        bit         chk;
        int         c0;
        int         lat;
    } exp_t;

    exp_t sb[$];
    int   total  = 0;
    int   passed = 0;
    int   cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Monitor: latency on the rising edge of out_valid, result on each handshake.
    initial begin
        exp_t e;
        logic prev_valid;
        prev_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_valid = 1'b0;
            end else begin
                if (out_valid && !prev_valid) begin
                    if (sb.size() == 0) check("spurious_out_valid", out_valid, 0);
                    else check("latency", cyc - sb[0].c0, sb[0].lat);
                end
                if (out_valid && out_ready && sb.size() > 0) begin
                    e = sb.pop_front();
                    if (e.chk) begin
                        check("quotient", quotient, e.q);
                        check("remainder", remainder, e.r);
                    end
                    check("err", err, e.e);
                end
                prev_valid = out_valid;
            end
        end
    end

    task automatic do_op(input logic [15:0] dvd, input logic [7:0] dvs,
                         input logic [7:0] eq, input logic [7:0] er, input logic ee,
                         input bit chk, input int lat, output int c0);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check("in_ready_timeout", in_ready, 1);
            c0 = -1;
            return;
        end
        dividend = dvd;
        divisor  = dvs;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        c0 = cyc;
        in_valid = 1'b0;
        sb.push_back('{eq, er, ee, chk, c0, lat});
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || !in_ready) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) check("drain_timeout", sb.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int c0;
        int c1;
        int n;
        int a;
        int b;
        int r;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        dividend  = '0;
        divisor   = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_quotient", quotient, 0);
        check("rst_remainder", remainder, 0);
        check("rst_err", err, 0);
        @(negedge clk);
        rst = 1'b0;

        // Boundaries
        do_op(16'hFEFF, 8'hFF, 8'hFF, 8'hFE, 1'b0, 1, 8, c0);
        wait_drain();
        do_op(16'h0000, 8'h01, 8'h00, 8'h00, 1'b0, 1, 8, c0);
        wait_drain();

        // Reset mid-RUN, then repeat the operation
        do_op(16'h0064, 8'h07, 8'h0E, 8'h02, 1'b0, 1, 8, c0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        sb.delete();
        check("midrst_in_ready", in_ready, 1);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_quotient", quotient, 0);
        check("midrst_remainder", remainder, 0);
        check("midrst_err", err, 0);
        @(negedge clk);
        rst = 1'b0;
        do_op(16'h0064, 8'h07, 8'h0E, 8'h02, 1'b0, 1, 8, c0);
        wait_drain();

        // Multiplier inverse
        do_op(16'hE1C8, 8'hF0, 8'hF0, 8'hC8, 1'b0, 1, 8, c0);
        wait_drain();

        // Overflow and divide-by-zero
`ifdef DIV_OVF_CHECK_EN
        do_op(16'h1234, 8'h12, 8'hFF, 8'h00, 1'b1, 1, 0, c0);
        wait_drain();
        do_op(16'h0005, 8'h00, 8'hFF, 8'h00, 1'b1, 1, 0, c0);
        wait_drain();
`else
        do_op(16'h1234, 8'h12, 8'h00, 8'h00, 1'b0, 0, 8, c0);
        wait_drain();
        do_op(16'h0005, 8'h00, 8'h00, 8'h00, 1'b0, 0, 8, c0);
        wait_drain();
`endif

        // Backpressure: result held, new operands ignored until handshake
        out_ready = 1'b0;
        do_op(16'hE1C8, 8'hF0, 8'hF0, 8'hC8, 1'b0, 1, 8, c0);
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("bp_reach_done", out_valid, 1);
        dividend = 16'h0064;
        divisor  = 8'h07;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_out_valid", out_valid, 1);
            check("bp_in_ready", in_ready, 0);
            check("bp_quotient", quotient, 8'hF0);
            check("bp_remainder", remainder, 8'hC8);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_idle_in_ready", in_ready, 1);
        check("bp_idle_out_valid", out_valid, 0);
        @(posedge clk);
        #1;
        c0 = cyc;
        check("bp_accepted", in_ready, 0);
        in_valid = 1'b0;
        sb.push_back('{8'h0E, 8'h02, 1'b0, 1'b1, c0, 8});
        wait_drain();

        // Back-to-back issue period with out_ready tied high
        do_op(16'h0064, 8'h07, 8'h0E, 8'h02, 1'b0, 1, 8, c0);
        do_op(16'hE1C8, 8'hF0, 8'hF0, 8'hC8, 1'b0, 1, 8, c1);
        check("issue_period", c1 - c0, 10);
        wait_drain();

        // Random multiplier-inverse sweep
        for (int i = 0; i < 1000; i++) begin
            a = $urandom_range(0, 255);
            b = $urandom_range(1, 255);
            r = $urandom_range(0, b - 1);
            do_op(16'(a * b + r), 8'(b), 8'(a), 8'(r), 1'b0, 1, 8, c0);
        end
        wait_drain();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
